dma_tsmap_arbiter: RTL
======================

Name: dma_tsmap_arbiter

Overview:
- Shares the single-port temporal-safety shadow map (tsmap) SRAM read port between the CPU core's revocation-check port and the DMA's free-check port.
- The core has absolute priority, because it cannot be stalled. The DMA is told when the port is occupied.
- Completed core reads are broadcast on a snoop bus, aligned with their data, so the DMA can abort transfers whose source or target was revoked.
- Sits between the core/DMA and the tsmap SRAM in the DMA-enabled core wrapper.

Parameters:
- TSMapSize, 2048: number of 32-bit tsmap words. Word addresses >= TSMapSize are out of range.
- StarveLimit, 64: consecutive DMA request cycles without a grant before dma_starved_o asserts.
- CntW, 8: width of the starvation counter. Must satisfy 2^CntW > StarveLimit.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- core_tsmap_cs_i  in  1  core read request (no grant; data expected next cycle)
- core_tsmap_addr_i  in  16  core tsmap word address
- core_tsmap_rdata_o  out  32  core read data
- dma_tsmap_cs_i  in  1  DMA read request, may be held for many cycles
- dma_tsmap_addr_i  in  16  DMA tsmap word address
- dma_tsmap_rdata_o  out  32  DMA read data, held between DMA grants
- dma_tsmap_occupied_o  out  1  port taken by core this cycle; DMA not granted
- dma_starved_o  out  1  DMA waited >= StarveLimit cycles
- mem_cs_o  out  1  SRAM chip select
- mem_addr_o  out  16  SRAM word address
- mem_rdata_i  in  32  SRAM data, valid the cycle after mem_cs_o
- snoop_cs_o  out  1  a core read completed this cycle
- snoop_addr_o  out  16  address of that read
- snoop_rdata_o  out  32  data of that read

Behaviour:
- Reset: asynchronous, active-low, clears all registers.
  - Outputs during reset: all rdata = 0, snoop_* = 0, dma_starved_o = 0, owner = OWN_NONE.
  - Reset mid-read: the in-flight response is dropped; no snoop is emitted.
- Grant logic, combinational, same cycle:
  - core_gnt = core_tsmap_cs_i.
  - dma_gnt = dma_tsmap_cs_i & !core_tsmap_cs_i.
  - dma_tsmap_occupied_o = core_tsmap_cs_i, independent of dma_tsmap_cs_i.
- Range check:
  - core_ok = core_addr < TSMapSize; dma_ok = dma_addr < TSMapSize (unsigned compare).
  - mem_cs_o = (core_gnt & core_ok) | (dma_gnt & dma_ok).
  - mem_addr_o = the granted address; otherwise 0.
- Owner register (resp_owner, updated each cycle), set to one of OWN_NONE, OWN_CORE, OWN_DMA, OWN_CORE_OOR, OWN_DMA_OOR from that cycle's grant and range result.
  - Registered alongside: resp_addr.
- Response cycle (cycle N+1 after a grant in cycle N):
  - OWN_CORE: core_tsmap_rdata_o = mem_rdata_i, and the value is captured. snoop_cs_o = 1, snoop_addr_o = resp_addr, snoop_rdata_o = mem_rdata_i.
  - OWN_CORE_OOR: core rdata = 0. No snoop.
  - OWN_DMA: dma_tsmap_rdata_o = mem_rdata_i, and the value is captured.
  - OWN_DMA_OOR: dma rdata = 32'hFFFF_FFFF (fail-safe: treated as revoked).
  - Otherwise: each rdata output holds its last captured value; snoop_cs_o = 0, snoop_addr_o = 0, snoop_rdata_o = 0.
- Read latency: exactly 1 cycle for both requesters. The core and DMA response paths are independent; a core response never corrupts the held DMA value.
- Starvation counter (starve_cnt):
  - Increments, saturating, while dma_tsmap_cs_i & core_tsmap_cs_i.
  - Clears on dma_gnt or on !dma_tsmap_cs_i.
  - dma_starved_o = (starve_cnt >= StarveLimit), registered.
  - Informational only; the core is never stalled.
- Simultaneous requests: the core wins. The DMA is granted on the first cycle the core deasserts, even if the DMA address changed meanwhile (the current address is used).
- Back-to-back core reads: one snoop per read, one cycle behind each request.

Decomposition:
- Shared package: owner_e typedef (OWN_NONE, OWN_CORE, OWN_DMA, OWN_CORE_OOR, OWN_DMA_OOR) and TSMAP_OOR_DATA = 32'hFFFF_FFFF.
- No sub-module. The response/hold path is small enough to stay inline.

Test Plan:
- DMA-only read:
  - Stimulus: dma cs=1, addr=0x0010; mem returns 0x0000_0004.
  - Response: occupied=0; mem_cs=1, addr=0x0010. Next cycle dma_rdata=0x4, held after cs drops. No snoop.
- Contention:
  - Stimulus: core cs and dma cs both high for 3 cycles; core addr 0x0020, DMA addr 0x0030.
  - Response: occupied=1 for 3 cycles; mem_addr=0x0020 each cycle; 3 snoops with addr=0x0020. Cycle 4: DMA granted at 0x0030; dma_rdata updates in cycle 5.
- Out of range:
  - Stimulus: DMA addr=2048.
  - Response: mem_cs=0; dma_rdata=0xFFFF_FFFF next cycle.
  - Stimulus: core addr=2048.
  - Response: core_rdata=0; no snoop.
- Snoop alignment:
  - Stimulus: core read at 0x0005, mem returns 0x8000_0000.
  - Response: next cycle snoop_cs=1, snoop_addr=0x0005, snoop_rdata=0x8000_0000, simultaneously with core_rdata.
- Starvation:
  - Stimulus: StarveLimit=4; core cs held 6 cycles with dma cs=1.
  - Response: dma_starved_o=1 from cycle 5; clears the cycle after the DMA grant.
- Reset mid-read:
  - Stimulus: rstn_i low in the response cycle of a core read.
  - Response: snoop_cs=0 and all rdata=0 immediately; no response after reset release.

Source files
------------

// File: rtl/dma_tsmap_arbiter_pkg.sv
// Shared types for the tsmap read-port arbiter: response owner encoding and fail-safe data.
// No timing of its own.
// No flow control of its own.
package dma_tsmap_arbiter_pkg;

  // Who owns the SRAM response arriving in the next cycle, and whether the
  // request was out of range (no SRAM access was made).
  typedef enum logic [2:0] {
    OWN_NONE     = 3'd0,
    OWN_CORE     = 3'd1,
    OWN_DMA      = 3'd2,
    OWN_CORE_OOR = 3'd3,
    OWN_DMA_OOR  = 3'd4
  } owner_e;

  // Returned to the DMA for out-of-range words so it treats them as revoked.
  localparam logic [31:0] TSMAP_OOR_DATA = 32'hFFFF_FFFF;

  // Unsigned word-address range check against the map size.
  function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned size);
    return {16'b0, addr} < size;
  endfunction

endpackage

// File: rtl/dma_tsmap_arbiter.sv
// Shares the tsmap SRAM read port between the core (absolute priority) and the DMA; snoops core reads.
// Latency: 1 cycle from request to rdata for both requesters; grant is combinational.
// Backpressure: core is never stalled; DMA sees occupied_o while the core holds the port, starved_o after a long wait.
module dma_tsmap_arbiter
  import dma_tsmap_arbiter_pkg::*;
#(
  parameter int unsigned TSMapSize   = 2048,
  parameter int unsigned StarveLimit = 64,
  // 2**CntW must exceed StarveLimit so the saturated count still reaches the limit.
  parameter int unsigned CntW        = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        core_tsmap_cs_i,
  input  logic [15:0] core_tsmap_addr_i,
  output logic [31:0] core_tsmap_rdata_o,
  input  logic        dma_tsmap_cs_i,
  input  logic [15:0] dma_tsmap_addr_i,
  output logic [31:0] dma_tsmap_rdata_o,
  output logic        dma_tsmap_occupied_o,
  output logic        dma_starved_o,
  output logic        mem_cs_o,
  output logic [15:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic        snoop_cs_o,
  output logic [15:0] snoop_addr_o,
  output logic [31:0] snoop_rdata_o
);

  logic core_gnt;
  logic dma_gnt;
  logic core_ok;
  logic dma_ok;

  owner_e      resp_owner_q, resp_owner_d;
  logic [15:0] resp_addr_q, resp_addr_d;
  logic [31:0] core_rdata_q, core_rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic        starved_q, starved_d;

  // Core always wins; the DMA only gets the port when the core is idle.
  assign core_gnt             = core_tsmap_cs_i;
  assign dma_gnt              = dma_tsmap_cs_i & ~core_tsmap_cs_i;
  assign dma_tsmap_occupied_o = core_tsmap_cs_i;

  assign core_ok = addr_in_range(core_tsmap_addr_i, TSMapSize);
  assign dma_ok  = addr_in_range(dma_tsmap_addr_i, TSMapSize);

  // SRAM request: only in-range granted reads touch the array; address is zero when idle.
  always_comb begin
    mem_cs_o   = 1'b0;
    mem_addr_o = '0;
    if (core_gnt) begin
      if (core_ok) begin
        mem_cs_o   = 1'b1;
        mem_addr_o = core_tsmap_addr_i;
      end
    end else if (dma_gnt) begin
      if (dma_ok) begin
        mem_cs_o   = 1'b1;
        mem_addr_o = dma_tsmap_addr_i;
      end
    end
  end

  // Next owner of the response slot, decided from this cycle's grant and range check.
  always_comb begin
    resp_owner_d = OWN_NONE;
    resp_addr_d  = '0;
    if (core_gnt) begin
      resp_owner_d = core_ok ? OWN_CORE : OWN_CORE_OOR;
      resp_addr_d  = core_tsmap_addr_i;
    end else if (dma_gnt) begin
      resp_owner_d = dma_ok ? OWN_DMA : OWN_DMA_OOR;
      resp_addr_d  = dma_tsmap_addr_i;
    end
  end

  // Response steering: the owner's path takes the new value (also captured), the other holds.
  always_comb begin
    core_rdata_d  = core_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    snoop_cs_o    = 1'b0;
    snoop_addr_o  = '0;
    snoop_rdata_o = '0;
    case (resp_owner_q)
      OWN_CORE: begin
        core_rdata_d  = mem_rdata_i;
        snoop_cs_o    = 1'b1;
        snoop_addr_o  = resp_addr_q;
        snoop_rdata_o = mem_rdata_i;
      end
      OWN_CORE_OOR: core_rdata_d = '0;
      OWN_DMA:      dma_rdata_d  = mem_rdata_i;
      OWN_DMA_OOR:  dma_rdata_d  = TSMAP_OOR_DATA;
      default: ;
    endcase
  end

  assign core_tsmap_rdata_o = core_rdata_d;
  assign dma_tsmap_rdata_o  = dma_rdata_d;

  // Starvation: count cycles the DMA is blocked by the core; any non-blocked cycle clears it.
  always_comb begin
    starve_cnt_d = '0;
    if (dma_tsmap_cs_i & core_tsmap_cs_i) begin
      starve_cnt_d = (starve_cnt_q == '1) ? starve_cnt_q : starve_cnt_q + CntW'(1);
    end
    starved_d = (32'(starve_cnt_d) >= StarveLimit);
  end

  assign dma_starved_o = starved_q;

  // State registers; reset drops any in-flight response by clearing the owner.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_owner_q <= OWN_NONE;
      resp_addr_q  <= '0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
      starve_cnt_q <= '0;
      starved_q    <= 1'b0;
    end else begin
      resp_owner_q <= resp_owner_d;
      resp_addr_q  <= resp_addr_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      starve_cnt_q <= starve_cnt_d;
      starved_q    <= starved_d;
    end
  end

endmodule
